dpram_initiator: RTL and testbench
==================================

Name: dpram_initiator

Overview:
- Dual-port request-side controller that turns two independent valid/ready command streams into the native `dpram` port signals.
- It registers address, write data, active-low write strobes and `en`, then captures `dpram` read data and returns it as per-port responses.
- Resolves same-address cross-port conflicts by stalling port 1, and counts those stalls.
- Sits between the two client masters and the `dpram` instance.

Parameters:
- ADDR_W, 6, address width (64-entry memory)
- DATA_W, 8, data width
- CNT_W, 8, width of the saturating collision counter

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- enable  input  1  global enable; low blocks new commands and drives mem_en low
- cmd0_valid  input  1  port 0 command valid
- cmd0_ready  output  1  port 0 command accepted when valid&ready
- cmd0_wr  input  1  1 = write, 0 = read
- cmd0_addr  input  ADDR_W  port 0 address
- cmd0_wdata  input  DATA_W  port 0 write data
- rsp0_valid  output  1  one-cycle pulse, port 0 read data valid
- rsp0_data  output  DATA_W  port 0 read data
- cmd1_valid, cmd1_ready, cmd1_wr, cmd1_addr, cmd1_wdata, rsp1_valid, rsp1_data: same as port 0, for port 1
- mem_en  output  1  to dpram en
- mem_wr0  output  1  to dpram wr0, active-low write
- mem_wr1  output  1  to dpram wr1, active-low write
- mem_add0  output  ADDR_W  to dpram add0
- mem_add1  output  ADDR_W  to dpram add1
- mem_data0_in  output  DATA_W  to dpram data0_in
- mem_data1_in  output  DATA_W  to dpram data1_in
- mem_data0_out  input  DATA_W  from dpram data0_out
- mem_data1_out  input  DATA_W  from dpram data1_out
- coll_cnt  output  CNT_W  count of port-1 collision stalls, saturating

Behaviour:
- Reset values:
  - mem_en=0, mem_wr0=mem_wr1=1 (no write)
  - mem_add*=0, mem_data*_in=0
  - rsp*_valid=0, rsp*_data=0, coll_cnt=0
  - all in-flight responses discarded; rst mid-operation drops pending reads and produces no rsp.
- cmd0_ready = enable. Port 0 always wins conflicts.
- Collision is defined as: cmd0_valid & cmd1_valid & (cmd0_addr==cmd1_addr) & (cmd0_wr | cmd1_wr).
- cmd1_ready = enable & !collision.
- Acceptance at edge A registers the mem_* outputs at A:
  - mem_add* = cmd addr
  - mem_data*_in = wdata
  - mem_wr* = !cmd_wr
  - mem_en = enable
- Port idle at edge A (no accept): mem_wr*=1, address and data held, no response scheduled.
- Read pipeline: dpram samples at A+1; the controller captures mem_data*_out at A+2. rsp*_valid=1 for exactly the cycle after A+2, with rsp*_data = captured value. Read latency is 2 cycles from acceptance.
- rsp*_data holds its last value while rsp*_valid=0.
- Writes produce no response. Fully pipelined: one command per port per cycle, back-to-back.
- Read after write, same address, issued in any later cycle returns the new data. No hazard logic is needed beyond the same-cycle collision stall.
- Both ports reading the same address: no collision; both accepted the same cycle.
- enable low at edge A:
  - mem_en registers 0 and no new commands are accepted.
  - Reads accepted before A still complete with valid data, because they were issued with mem_en=1.
- coll_cnt increments by 1 on every cycle where collision & enable. It saturates at 2^CNT_W-1 and does not wrap.
- No rsp backpressure: clients must sink rsp pulses.

Decomposition:
- Package dpram_pkg: ADDR_W, DATA_W, CNT_W defaults; MEM_WR_ACTIVE=1'b0; MEM_DEPTH=64.
- Sub-module dpram_init_port: one per port, two instances.
  - Owns the mem_add/data/wr registers.
  - Owns the 2-stage read-tag shift pipeline and the rsp capture register.
- The top level holds the collision/ready logic and coll_cnt.

Test Plan:
- Reset then enable=1; port0 write addr 5 data 8'hA5; port0 read addr 5 next cycle -> mem_wr0=0 for one cycle; rsp0_valid 2 cycles after read accept, rsp0_data=8'hA5.
- Port0 write addr 10 data 8'h3C and port1 read addr 10 in the same cycle -> cmd1_ready=0 that cycle, coll_cnt=1; port1 read accepted next cycle, rsp1_data=8'h3C.
- Both ports read addr 7 (preloaded 8'h77) simultaneously -> both ready, no collision, rsp0_data=rsp1_data=8'h77 in the same cycle.
- Back-to-back port1 reads of addrs 0..63 after writing data=addr -> 64 consecutive rsp1_valid pulses, data 0..63 in order, no gaps.
- Hold a port0/port1 write-write collision on addr 3 for 300 cycles -> coll_cnt saturates at 255; memory holds port0 data.
- rst asserted one cycle after a read accept -> outputs reset immediately, no rsp*_valid pulse; enable=0 -> cmd*_ready=0, mem_en=0 next edge.

Source files
------------

// File: rtl/dpram_pkg.sv
// ---------------------------------------------------------------------------
// dpram_pkg
//   Shared constants for the dual-port RAM request-side controller.
//   ADDR_W / DATA_W / CNT_W : default address, data and collision-counter widths
//   MEM_DEPTH               : number of entries in the attached dpram
//   MEM_WR_ACTIVE/IDLE      : levels of the dpram's active-low write strobes
// ---------------------------------------------------------------------------
package dpram_pkg;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 8;
    localparam int MEM_DEPTH = 64;

    localparam logic MEM_WR_ACTIVE = 1'b0;
    localparam logic MEM_WR_IDLE   = 1'b1;

endpackage : dpram_pkg

// File: rtl/dpram_initiator_if.sv
// ---------------------------------------------------------------------------
// dpram_initiator_if
//   One client port of the dpram controller: a command stream and a
//   response pulse.
//
//   Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both 1. cmd_valid may not depend on cmd_ready; while
//   cmd_valid is 1 and cmd_ready is 0 the master holds cmd_wr, cmd_addr and
//   cmd_wdata stable. rsp_valid is a single-cycle pulse with no backpressure;
//   the master must accept rsp_data in that cycle.
//
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  command accepted this cycle
//   cmd_wr     master->slave  1 = write, 0 = read
//   cmd_addr   master->slave  word address
//   cmd_wdata  master->slave  write data
//   rsp_valid  slave->master  read data valid (one-cycle pulse)
//   rsp_data   slave->master  read data, held between pulses
// ---------------------------------------------------------------------------
interface dpram_initiator_if #(
    parameter int ADDR_W = dpram_pkg::ADDR_W,
    parameter int DATA_W = dpram_pkg::DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface : dpram_initiator_if

// File: rtl/dpram_init_port.sv
// ---------------------------------------------------------------------------
// dpram_init_port
//   Per-port datapath: registers the dpram address/data/write-strobe for an
//   accepted command and tracks outstanding reads through a 2-stage tag
//   pipeline so the dpram's registered read data can be returned as a
//   one-cycle response pulse.
//
//   clk, rst      clock / asynchronous active-high reset
//   accept        command transfers on this edge (valid & ready)
//   cmd_wr        1 = write, 0 = read
//   cmd_addr      command address
//   cmd_wdata     command write data
//   mem_wr        dpram write strobe (active low)
//   mem_add       dpram address
//   mem_data_in   dpram write data
//   mem_data_out  dpram read data
//   rsp_valid     read response pulse
//   rsp_data      read response data, held between pulses
// ---------------------------------------------------------------------------
module dpram_init_port
    import dpram_pkg::*;
#(
    parameter int ADDR_W = dpram_pkg::ADDR_W,
    parameter int DATA_W = dpram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data
);

    // rd_s1: read issued to the dpram this cycle (dpram samples next edge).
    // rd_s2: dpram read data for that read is on mem_data_out now.
    logic rd_s1;
    logic rd_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr      <= MEM_WR_IDLE;
            mem_add     <= '0;
            mem_data_in <= '0;
        end else if (accept) begin
            mem_wr      <= cmd_wr ? MEM_WR_ACTIVE : MEM_WR_IDLE;
            mem_add     <= cmd_addr;
            mem_data_in <= cmd_wdata;
        end else begin
            // Address and data are held so an idle port does not toggle the bus.
            mem_wr      <= MEM_WR_IDLE;
        end
    end

    // The read pipeline runs regardless of enable: a read issued while
    // enabled still completes after enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_s1     <= 1'b0;
            rd_s2     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rd_s1     <= accept & ~cmd_wr;
            rd_s2     <= rd_s1;
            rsp_valid <= rd_s2;
            if (rd_s2) begin
                rsp_data <= mem_data_out;
            end
        end
    end

endmodule : dpram_init_port

// File: rtl/dpram_initiator.sv
// ---------------------------------------------------------------------------
// dpram_initiator
//   Request-side controller between two client masters and a dual-port RAM.
//   Each port accepts one command per cycle; same-address conflicts where at
//   least one side writes are resolved in favour of port 0 by withholding
//   cmd_ready from port 1, and every such stall is counted.
//
//   clk, rst        clock / asynchronous active-high reset
//   enable          global enable; low blocks commands and drops mem_en
//   p0, p1          client ports (command stream + response pulse)
//   mem_en          dpram enable
//   mem_wr0/1       dpram write strobes (active low)
//   mem_add0/1      dpram addresses
//   mem_data0/1_in  dpram write data
//   mem_data0/1_out dpram read data
//   coll_cnt        saturating count of port-1 collision stalls
// ---------------------------------------------------------------------------
module dpram_initiator
    import dpram_pkg::*;
#(
    parameter int ADDR_W = dpram_pkg::ADDR_W,
    parameter int DATA_W = dpram_pkg::DATA_W,
    parameter int CNT_W  = dpram_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    dpram_initiator_if.slave  p0,
    dpram_initiator_if.slave  p1,
    output logic              mem_en,
    output logic              mem_wr0,
    output logic              mem_wr1,
    output logic [ADDR_W-1:0] mem_add0,
    output logic [ADDR_W-1:0] mem_add1,
    output logic [DATA_W-1:0] mem_data0_in,
    output logic [DATA_W-1:0] mem_data1_in,
    input  logic [DATA_W-1:0] mem_data0_out,
    input  logic [DATA_W-1:0] mem_data1_out,
    output logic [CNT_W-1:0]  coll_cnt
);

    logic collision;
    logic accept0;
    logic accept1;

    // Two reads of the same word are harmless; anything involving a write
    // to the same word would race inside the dpram, so port 1 waits.
    assign collision = p0.cmd_valid & p1.cmd_valid &
                       (p0.cmd_addr == p1.cmd_addr) &
                       (p0.cmd_wr | p1.cmd_wr);

    assign p0.cmd_ready = enable;
    assign p1.cmd_ready = enable & ~collision;

    assign accept0 = p0.cmd_valid & p0.cmd_ready;
    assign accept1 = p1.cmd_valid & p1.cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en <= 1'b0;
        end else begin
            mem_en <= enable;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_cnt <= '0;
        end else if (collision && enable && (coll_cnt != {CNT_W{1'b1}})) begin
            coll_cnt <= coll_cnt + CNT_W'(1);
        end
    end

    dpram_init_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port0 (
        .clk          (clk),
        .rst          (rst),
        .accept       (accept0),
        .cmd_wr       (p0.cmd_wr),
        .cmd_addr     (p0.cmd_addr),
        .cmd_wdata    (p0.cmd_wdata),
        .mem_wr       (mem_wr0),
        .mem_add      (mem_add0),
        .mem_data_in  (mem_data0_in),
        .mem_data_out (mem_data0_out),
        .rsp_valid    (p0.rsp_valid),
        .rsp_data     (p0.rsp_data)
    );

    dpram_init_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port1 (
        .clk          (clk),
        .rst          (rst),
        .accept       (accept1),
        .cmd_wr       (p1.cmd_wr),
        .cmd_addr     (p1.cmd_addr),
        .cmd_wdata    (p1.cmd_wdata),
        .mem_wr       (mem_wr1),
        .mem_add      (mem_add1),
        .mem_data_in  (mem_data1_in),
        .mem_data_out (mem_data1_out),
        .rsp_valid    (p1.rsp_valid),
        .rsp_data     (p1.rsp_data)
    );

endmodule : dpram_initiator

// File: tb/tb_dpram_initiator.sv
// ---------------------------------------------------------------------------
// tb_dpram_initiator
//   Directed bench for dpram_initiator with a behavioural registered-read
//   dual-port RAM attached to the mem_* bus. Inputs change and outputs are
//   sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dpram_initiator;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          mem_en;
    logic          mem_wr0;
    logic          mem_wr1;
    logic [AW-1:0] mem_add0;
    logic [AW-1:0] mem_add1;
    logic [DW-1:0] mem_data0_in;
    logic [DW-1:0] mem_data1_in;
    logic [DW-1:0] mem_data0_out;
    logic [DW-1:0] mem_data1_out;
    logic [CW-1:0] coll_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] exp_q[$];

    dpram_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
    dpram_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

    dpram_initiator #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .p0            (p0_if),
        .p1            (p1_if),
        .mem_en        (mem_en),
        .mem_wr0       (mem_wr0),
        .mem_wr1       (mem_wr1),
        .mem_add0      (mem_add0),
        .mem_add1      (mem_add1),
        .mem_data0_in  (mem_data0_in),
        .mem_data1_in  (mem_data1_in),
        .mem_data0_out (mem_data0_out),
        .mem_data1_out (mem_data1_out),
        .coll_cnt      (coll_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural dpram ----------------
    logic [DW-1:0] ram [64];

    always @(posedge clk) begin
        if (mem_en) begin
            if (!mem_wr1) ram[mem_add1] <= mem_data1_in;
            if (!mem_wr0) ram[mem_add0] <= mem_data0_in;
            mem_data0_out <= ram[mem_add0];
            mem_data1_out <= ram[mem_add1];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive0(input logic v, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_if.cmd_valid = v;
        p0_if.cmd_wr    = wr;
        p0_if.cmd_addr  = a;
        p0_if.cmd_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_if.cmd_valid = v;
        p1_if.cmd_wr    = wr;
        p1_if.cmd_addr  = a;
        p1_if.cmd_wdata = d;
    endtask

    task automatic idle_both();
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        idle_both();
        repeat (3) @(negedge clk);
        tests_run++;
        if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
        tests_run++;
        if ({mem_wr0, mem_wr1} !== 2'b11) begin tests_failed++; $display("FAIL reset_mem_wr got %b want 11", {mem_wr0, mem_wr1}); end
        tests_run++;
        if ({mem_add0, mem_add1, mem_data0_in, mem_data1_in} !== '0) begin
            tests_failed++; $display("FAIL reset_bus got %h/%h/%h/%h want 0", mem_add0, mem_add1, mem_data0_in, mem_data1_in);
        end
        tests_run++;
        if ({p0_if.rsp_valid, p1_if.rsp_valid, p0_if.rsp_data, p1_if.rsp_data, coll_cnt} !== '0) begin
            tests_failed++; $display("FAIL reset_rsp_cnt got v=%b%b d=%h/%h cnt=%0d want 0", p0_if.rsp_valid, p1_if.rsp_valid, p0_if.rsp_data, p1_if.rsp_data, coll_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int k;
        enable = 1'b1;
        drive0(1'b1, 1'b1, 6'd5, 8'hA5);
        @(negedge clk);
        tests_run++;
        if ({mem_en, mem_wr0, mem_add0, mem_data0_in} !== {1'b1, 1'b0, 6'd5, 8'hA5}) begin
            tests_failed++; $display("FAIL wr_issue got en=%b wr0=%b a=%0d d=%h want 1 0 5 a5", mem_en, mem_wr0, mem_add0, mem_data0_in);
        end
        drive0(1'b1, 1'b0, 6'd5, 8'h00);
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                tests_run++;
                if (mem_wr0 !== 1'b1) begin tests_failed++; $display("FAIL wr_one_cycle got wr0=%b want 1", mem_wr0); end
                drive0(1'b0, 1'b0, '0, '0);
            end
            if (p0_if.rsp_valid === 1'b1) begin k = i; break; end
        end
        tests_run++;
        if (k !== 3) begin tests_failed++; $display("FAIL rd0_latency got %0d want 3", k); end
        tests_run++;
        if (p0_if.rsp_data !== 8'hA5) begin tests_failed++; $display("FAIL rd0_data got %h want a5", p0_if.rsp_data); end
        @(negedge clk);
        tests_run++;
        if ({p0_if.rsp_valid, p0_if.rsp_data} !== {1'b0, 8'hA5}) begin
            tests_failed++; $display("FAIL rd0_hold got v=%b d=%h want 0 a5", p0_if.rsp_valid, p0_if.rsp_data);
        end
    endtask

    task automatic test_collision();
        int k;
        drive0(1'b1, 1'b1, 6'd10, 8'h3C);
        drive1(1'b1, 1'b0, 6'd10, 8'h00);
        #1;
        tests_run++;
        if ({p0_if.cmd_ready, p1_if.cmd_ready} !== 2'b10) begin
            tests_failed++; $display("FAIL coll_ready got %b%b want 10", p0_if.cmd_ready, p1_if.cmd_ready);
        end
        @(negedge clk);
        tests_run++;
        if (coll_cnt !== 8'd1) begin tests_failed++; $display("FAIL coll_cnt1 got %0d want 1", coll_cnt); end
        drive0(1'b0, 1'b0, '0, '0);
        #1;
        tests_run++;
        if (p1_if.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL coll_retry_ready got %b want 1", p1_if.cmd_ready); end
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) drive1(1'b0, 1'b0, '0, '0);
            if (p1_if.rsp_valid === 1'b1) begin k = i; break; end
        end
        tests_run++;
        if ({k, p1_if.rsp_data} !== {32'd3, 8'h3C}) begin
            tests_failed++; $display("FAIL coll_rd1 got lat=%0d d=%h want 3 3c", k, p1_if.rsp_data);
        end
        tests_run++;
        if (coll_cnt !== 8'd1) begin tests_failed++; $display("FAIL coll_cnt_stable got %0d want 1", coll_cnt); end
    endtask

    task automatic test_dual_read();
        int k0;
        int k1;
        drive0(1'b1, 1'b1, 6'd7, 8'h77);
        @(negedge clk);
        drive0(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        drive0(1'b1, 1'b0, 6'd7, 8'h00);
        drive1(1'b1, 1'b0, 6'd7, 8'h00);
        #1;
        tests_run++;
        if ({p0_if.cmd_ready, p1_if.cmd_ready} !== 2'b11) begin
            tests_failed++; $display("FAIL dual_ready got %b%b want 11", p0_if.cmd_ready, p1_if.cmd_ready);
        end
        k0 = 0;
        k1 = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) idle_both();
            if (p0_if.rsp_valid === 1'b1 && k0 == 0) k0 = i;
            if (p1_if.rsp_valid === 1'b1 && k1 == 0) k1 = i;
            if (k0 != 0 && k1 != 0) break;
        end
        tests_run++;
        if ({k0, k1, p0_if.rsp_data, p1_if.rsp_data} !== {32'd3, 32'd3, 8'h77, 8'h77}) begin
            tests_failed++; $display("FAIL dual_rsp got lat=%0d/%0d d=%h/%h want 3/3 77/77", k0, k1, p0_if.rsp_data, p1_if.rsp_data);
        end
        tests_run++;
        if (coll_cnt !== 8'd1) begin tests_failed++; $display("FAIL dual_no_coll got cnt=%0d want 1", coll_cnt); end
    endtask

    task automatic test_enable_low();
        int k;
        drive0(1'b1, 1'b0, 6'd7, 8'h00);
        @(negedge clk);
        drive0(1'b0, 1'b0, '0, '0);
        enable = 1'b0;
        #1;
        tests_run++;
        if ({p0_if.cmd_ready, p1_if.cmd_ready} !== 2'b00) begin
            tests_failed++; $display("FAIL en_low_ready got %b%b want 00", p0_if.cmd_ready, p1_if.cmd_ready);
        end
        k = 0;
        for (int i = 2; i <= 6; i++) begin
            @(negedge clk);
            if (i == 2) begin
                tests_run++;
                if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL en_low_mem_en got %b want 0", mem_en); end
                drive0(1'b1, 1'b1, 6'd20, 8'hFF);
            end
            if (p0_if.rsp_valid === 1'b1) begin k = i; break; end
        end
        tests_run++;
        if ({k, p0_if.rsp_data} !== {32'd3, 8'h77}) begin
            tests_failed++; $display("FAIL en_low_inflight got lat=%0d d=%h want 3 77", k, p0_if.rsp_data);
        end
        tests_run++;
        if ({mem_wr0, mem_add0} !== {1'b1, 6'd7}) begin
            tests_failed++; $display("FAIL en_low_blocked got wr0=%b a=%0d want 1 7", mem_wr0, mem_add0);
        end
        drive0(1'b0, 1'b0, '0, '0);
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int pulses;
        int gaps;
        int bad;
        bit seen;
        logic [DW-1:0] exp;
        for (int i = 0; i < 64; i++) begin
            drive0(1'b1, 1'b1, AW'(i), DW'(i));
            @(negedge clk);
        end
        drive0(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        pulses = 0;
        gaps   = 0;
        bad    = 0;
        seen   = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 72; i++) begin
            if (p1_if.rsp_valid === 1'b1) begin
                seen = 1'b1;
                pulses++;
                if (exp_q.size() == 0) begin
                    bad++;
                end else begin
                    exp = exp_q.pop_front();
                    if (p1_if.rsp_data !== exp) bad++;
                end
            end else if (seen && pulses < 64) begin
                gaps++;
            end
            if (i < 64) begin
                drive1(1'b1, 1'b0, AW'(i), 8'h00);
                if (p1_if.cmd_ready !== 1'b1) bad++;
                exp_q.push_back(DW'(i));
            end else begin
                drive1(1'b0, 1'b0, '0, '0);
            end
            @(negedge clk);
        end
        tests_run++;
        if (pulses !== 64) begin tests_failed++; $display("FAIL b2b_pulses got %0d want 64", pulses); end
        tests_run++;
        if (gaps !== 0) begin tests_failed++; $display("FAIL b2b_gaps got %0d want 0", gaps); end
        tests_run++;
        if (bad !== 0 || exp_q.size() != 0) begin
            tests_failed++; $display("FAIL b2b_data got %0d bad, %0d left want 0 0", bad, exp_q.size());
        end
    endtask

    task automatic test_saturation();
        int k;
        drive0(1'b1, 1'b1, 6'd3, 8'h5A);
        drive1(1'b1, 1'b1, 6'd3, 8'hC3);
        repeat (100) @(negedge clk);
        tests_run++;
        if (coll_cnt !== 8'd101) begin tests_failed++; $display("FAIL sat_mid got %0d want 101", coll_cnt); end
        tests_run++;
        if ({p1_if.cmd_ready, mem_wr1} !== 2'b01) begin
            tests_failed++; $display("FAIL sat_stall got ready1=%b wr1=%b want 0 1", p1_if.cmd_ready, mem_wr1);
        end
        repeat (200) @(negedge clk);
        tests_run++;
        if (coll_cnt !== 8'd255) begin tests_failed++; $display("FAIL sat_max got %0d want 255", coll_cnt); end
        idle_both();
        @(negedge clk);
        drive0(1'b1, 1'b0, 6'd3, 8'h00);
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) drive0(1'b0, 1'b0, '0, '0);
            if (p0_if.rsp_valid === 1'b1) begin k = i; break; end
        end
        tests_run++;
        if ({k, p0_if.rsp_data} !== {32'd3, 8'h5A}) begin
            tests_failed++; $display("FAIL sat_mem got lat=%0d d=%h want 3 5a", k, p0_if.rsp_data);
        end
        tests_run++;
        if (coll_cnt !== 8'd255) begin tests_failed++; $display("FAIL sat_hold got %0d want 255", coll_cnt); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        drive0(1'b1, 1'b0, 6'd5, 8'h00);
        @(negedge clk);
        drive0(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({mem_en, mem_add0, p0_if.rsp_valid, coll_cnt} !== '0) begin
            tests_failed++; $display("FAIL rst_mid_async got en=%b a=%0d v=%b cnt=%0d want 0", mem_en, mem_add0, p0_if.rsp_valid, coll_cnt);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            if (p0_if.rsp_valid === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin tests_failed++; $display("FAIL rst_mid_no_rsp got %0d pulses want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_dual_read();
        test_enable_low();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_dpram_initiator
